// File: rtl/axi_delay_regs_pkg.sv
// Shared constants and FSM encodings for the delay-word register slave.
package axi_delay_regs_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ADDR_LSB    = 2;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}           r_state_e;
endpackage

// File: rtl/axi_delay_slave_regs_if.sv
// AXI4-Lite bus bundle between the VIP master and the delay register slave.
interface axi_delay_slave_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid, wready;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid, rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi_delay_shadow_bank.sv
// Frame-synchronous shadow of the live delay bank. The snapshot is taken on the
// frame_sync edge itself so a commit in that same cycle lands at the next frame.
module axi_delay_shadow_bank #(
  parameter int NUM_REGS = 4,
  parameter int DW       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_sync,
  input  logic [NUM_REGS-1:0][DW-1:0]  live,
  output logic [DW*NUM_REGS-1:0]       delay_o,
  output logic                         update_o
);
  localparam int STAGES = 2;

  logic [STAGES:1]              vld_pipe;
  logic [NUM_REGS-1:0][DW-1:0]  snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      snap     <= '0;
      delay_o  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], frame_sync};
      if (frame_sync)  snap    <= live;
      if (vld_pipe[1]) delay_o <= snap;
    end
  end

  assign update_o = vld_pipe[STAGES];
endmodule

// File: rtl/axi_delay_slave_regs.sv
// AXI4-Lite slave holding per-channel delay words; the delay core sees them
// only through the frame-synchronous shadow bank.
module axi_delay_slave_regs
  import axi_delay_regs_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  axi_delay_slave_regs_if.slave              s_axi,
  input  logic                               frame_sync,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] delay_o,
  output logic                               update_o
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DW / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  logic [NUM_REGS-1:0][DW-1:0] regs;

  // ---------------- write channel ----------------
  w_state_e           w_state;
  logic               aw_lat, w_lat;
  logic [IDX_W-1:0]   aw_idx;
  logic [DW-1:0]      wdata_q;
  logic [STRB_W-1:0]  wstrb_q;
  logic [1:0]         bresp_q;
  logic               aw_hs, w_hs, aw_ok;

  // READY depends only on state, never on the incoming VALIDs.
  assign s_axi.awready = !ARESET && (w_state == W_IDLE) && !aw_lat;
  assign s_axi.wready  = !ARESET && (w_state == W_IDLE) && !w_lat;
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bresp   = bresp_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign aw_ok = 32'(aw_idx) < 32'(NUM_REGS);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_lat  <= 1'b0;
      w_lat   <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= RESP_OKAY;
      regs    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_lat <= 1'b1;
            aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
          end
          if (w_hs) begin
            w_lat   <= 1'b1;
            wdata_q <= s_axi.wdata;
            wstrb_q <= s_axi.wstrb;
          end
          if ((aw_lat || aw_hs) && (w_lat || w_hs)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          // Out-of-range indices match no register, so the write is dropped.
          for (int i = 0; i < NUM_REGS; i++)
            if (aw_idx == IDX_W'(i))
              for (int b = 0; b < STRB_W; b++)
                if (wstrb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
          bresp_q <= aw_ok ? RESP_OKAY : RESP_SLVERR;
          aw_lat  <= 1'b0;
          w_lat   <= 1'b0;
          w_state <= W_RESP;
        end
        W_RESP:  if (s_axi.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_e          r_state;
  logic [IDX_W-1:0]  ar_idx;
  logic [DW-1:0]     rd_word;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;

  assign ar_idx        = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign s_axi.arready = !ARESET && (r_state == R_IDLE);
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_word = regs[i];
  end

  // Capture sees regs before any same-edge commit, giving pre-write data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi.arvalid) begin
          rdata_q <= rd_word;
          rresp_q <= (32'(ar_idx) < 32'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
          r_state <= R_DATA;
        end
        R_DATA:  if (s_axi.rready) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  axi_delay_shadow_bank #(.NUM_REGS(NUM_REGS), .DW(DW)) u_shadow (
    .clk        (ACLK),
    .rst        (ARESET),
    .frame_sync (frame_sync),
    .live       (regs),
    .delay_o    (delay_o),
    .update_o   (update_o)
  );
endmodule

// File: tb/tb_axi_delay_slave_regs.sv
// Bench for axi_delay_slave_regs: directed vector table, hand-written corner
// sequences and randomized traffic against an array-based register model.
module tb_axi_delay_slave_regs;
  localparam int AW = 5;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_sync = 1'b0;
  logic [32*NR-1:0] delay_o;
  logic            update_o;

  axi_delay_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axi_delay_slave_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)
  ) dut (
    .ACLK       (clk),
    .ARESET     (rst),
    .s_axi      (bus.slave),
    .frame_sync (frame_sync),
    .delay_o    (delay_o),
    .update_o   (update_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs   [NR];
  logic [31:0] m_shadow [NR];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT handshake", name);
  endtask

  function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
    return ((addr >> 2) < NR) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr >> 2);
    if (idx < NR)
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
    int idx = int'(addr >> 2);
    return (idx < NR) ? m_regs[idx] : 32'h0;
  endfunction

  function automatic logic [127:0] shadow_vec();
    logic [127:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = m_shadow[i];
    return v;
  endfunction

  // Wait for BVALID, optionally stall BREADY, then take the response.
  task automatic wait_bresp(input int bdelay, output logic [1:0] resp);
    int budget = 0;
    do begin @(negedge clk); budget++; end while (!bus.bvalid && budget < 50);
    if (!bus.bvalid) begin fail_to("bvalid_wait"); resp = 2'bxx; return; end
    for (int k = 0; k < bdelay; k++) begin
      chk("bvalid_held", bus.bvalid, 1'b1);
      chk("awready_low_in_resp", bus.awready, 1'b0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bdelay, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_go, w_go;
    int budget = 0;
    int aw_start = (lead > 0) ? lead : 0;
    int w_start  = (lead < 0) ? -lead : 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    while (!(aw_done && w_done)) begin
      if (budget >= 50) begin fail_to("aw_w_accept"); resp = 2'bxx; return; end
      if (!aw_done && budget >= aw_start) bus.awvalid = 1'b1;
      if (!w_done  && budget >= w_start)  bus.wvalid  = 1'b1;
      @(negedge clk);
      if (w_done && !aw_done) chk("wready_low_while_latched", bus.wready, 1'b0);
      if (aw_done && !w_done) chk("awready_low_while_latched", bus.awready, 1'b0);
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid  && bus.wready;
      @(posedge clk); #1;
      if (aw_go) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_go)  begin w_done  = 1; bus.wvalid  = 1'b0; end
      budget++;
    end
    wait_bresp(bdelay, resp);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int budget = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    do begin @(negedge clk); budget++; end while (!bus.arready && budget < 50);
    if (!bus.arready) begin fail_to("arready_wait"); bus.arvalid = 1'b0; data = 'x; resp = 'x; return; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!bus.rvalid && budget < 50);
    if (!bus.rvalid) begin fail_to("rvalid_wait"); data = 'x; resp = 'x; return; end
    bus.rready = 1'b1;
    data = bus.rdata;
    resp = bus.rresp;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  // Pulse frame_sync for one sampled edge and check the shadow pipeline.
  task automatic pulse_fs();
    logic [127:0] prev = shadow_vec();
    for (int i = 0; i < NR; i++) m_shadow[i] = m_regs[i];
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
    chk("shadow_not_early", delay_o, prev);
    chk("update_not_early", update_o, 1'b0);
    @(posedge clk); #1;
    chk("shadow_loaded", delay_o, shadow_vec());
    chk("update_pulse", update_o, 1'b1);
    @(posedge clk); #1;
    chk("update_single", update_o, 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic [1:0]  rs;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0; bus.bready = 0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_shadow[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.awready, 1'b0);
    chk("rst_wready",  bus.wready,  1'b0);
    chk("rst_arready", bus.arready, 1'b0);
    chk("rst_bvalid",  bus.bvalid,  1'b0);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 36'h0);
    chk("rst_delay_o", delay_o, 128'h0);
    chk("rst_update_o", update_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;

    // Directed vectors; expected values worked out by hand
    tbl.push_back('{1, 5'h00, 32'h1, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1, 5'h04, 32'h2, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1, 5'h08, 32'h3, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1, 5'h0C, 32'h4, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00});
    tbl.push_back('{0, 5'h04, 32'h0, 4'h0, 32'h2, 2'b00});
    tbl.push_back('{0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00});
    tbl.push_back('{0, 5'h0C, 32'h0, 4'h0, 32'h4, 2'b00});
    tbl.push_back('{1, 5'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1, 5'h04, 32'h00000000, 4'h5, 32'h0, 2'b00});
    tbl.push_back('{0, 5'h04, 32'h0, 4'h0, 32'hFF00FF00, 2'b00});
    tbl.push_back('{1, 5'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b10});
    tbl.push_back('{0, 5'h10, 32'h0, 4'h0, 32'h0, 2'b10});
    tbl.push_back('{0, 5'h1D, 32'h0, 4'h0, 32'h0, 2'b10});
    tbl.push_back('{0, 5'h00, 32'h0, 4'h0, 32'h1, 2'b00});
    tbl.push_back('{0, 5'h08, 32'h0, 4'h0, 32'h3, 2'b00});
    tbl.push_back('{0, 5'h0E, 32'h0, 4'h0, 32'h4, 2'b00});
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, rs);
        chk($sformatf("tbl%0d_bresp", i), rs, tbl[i].exp_resp);
        model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        do_read(tbl[i].addr, rd, rs);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
        chk($sformatf("tbl%0d_rresp", i), rs, tbl[i].exp_resp);
      end
    end

    // W three cycles ahead of AW, then BREADY held off for 5 cycles
    do_write(5'h08, 32'h12345678, 4'hF, 3, 5, rs);
    chk("wfirst_bresp", rs, 2'b00);
    model_write(5'h08, 32'h12345678, 4'hF);
    do_read(5'h08, rd, rs);
    chk("wfirst_rdata", rd, 32'h12345678);
    do_write(5'h0C, 32'hCAFE0000, 4'hC, -2, 0, rs);
    model_write(5'h0C, 32'hCAFE0000, 4'hC);
    do_read(5'h0C, rd, rs);
    chk("awfirst_rdata", rd, 32'hCAFE0004);

    // Shadow timing, then frame_sync landing on the commit cycle
    do_write(5'h00, 32'h10, 4'hF, 0, 0, rs);
    model_write(5'h00, 32'h10, 4'hF);
    pulse_fs();
    chk("shadow_reg0", delay_o[31:0], 32'h10);
    bus.awaddr = 5'h00; bus.wdata = 32'h20; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    chk("coinc_ready", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    frame_sync = 1'b1;
    for (int i = 0; i < NR; i++) m_shadow[i] = m_regs[i];
    @(posedge clk); #1;
    frame_sync = 1'b0;
    wait_bresp(0, rs);
    model_write(5'h00, 32'h20, 4'hF);
    chk("coinc_update", update_o, 1'b1);
    chk("coinc_shadow_prewrite", delay_o[31:0], 32'h10);
    chk("coinc_shadow_all", delay_o, shadow_vec());
    @(posedge clk); #1;
    chk("coinc_update_single", update_o, 1'b0);
    do_read(5'h00, rd, rs);
    chk("coinc_live", rd, 32'h20);
    chk("coinc_shadow_kept", delay_o[31:0], 32'h10);
    pulse_fs();
    chk("shadow_next_frame", delay_o[31:0], 32'h20);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a  = AW'($urandom_range(0, 31));
      logic [31:0]   d  = $urandom;
      logic [3:0]    s  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)), rs);
        chk("rand_bresp", rs, exp_resp(a));
        model_write(a, d, s);
      end else begin
        do_read(a, rd, rs);
        chk("rand_rdata", rd, model_read(a));
        chk("rand_rresp", rs, exp_resp(a));
      end
      if ($urandom_range(0, 9) == 0) pulse_fs();
    end

    // Reset while BVALID is pending
    bus.awaddr = 5'h08; bus.wdata = 32'hAAAA5555; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    begin
      int budget = 0;
      do begin @(negedge clk); budget++; end while (!bus.bvalid && budget < 10);
    end
    chk("pre_rst_bvalid", bus.bvalid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_bvalid", bus.bvalid, 1'b0);
    chk("midrst_delay_o", delay_o, 128'h0);
    chk("midrst_update", update_o, 1'b0);
    chk("midrst_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_shadow[i] = 0; end
    @(negedge clk);
    chk("postrst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(4 * i), rd, rs);
      chk("postrst_reg_zero", rd, 32'h0);
    end
    do_write(5'h00, 32'h5A5A1234, 4'hF, 0, 0, rs);
    chk("postrst_bresp", rs, 2'b00);
    do_read(5'h00, rd, rs);
    chk("postrst_rdata", rd, 32'h5A5A1234);
    chk("postrst_rresp", rs, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
